psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
Shares the single PSRAM controller port between two requesters: the CPU bus and a video line-fetch engine. It runs at clk_100mhz and presents one 16-bit, word-granular transaction at a time to the PSRAM controller's stb/we/addr/din/busy/done interface. Video has priority; a streak limit guarantees CPU forward progress. A watchdog terminates transactions the controller never completes.

Parameters:
ADDR_W, 24, PSRAM word address width
DATA_W, 16, data width
MAX_VID_STREAK, 4, max consecutive video grants while cpu_req is pending
TIMEOUT, 255, cycles in WAIT before a forced completion

Ports:
clk_100mhz  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU request; held stable until cpu_ack
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  CPU read data; valid while cpu_ack is high
vid_req  in  1  video read request; held until vid_ack
vid_addr  in  ADDR_W  video word address
vid_ack  out  1  one-cycle completion pulse to video
vid_rdata  out  DATA_W  video read data; valid while vid_ack is high
mem_stb  out  1  one-cycle transaction strobe to the PSRAM controller
mem_we  out  1  write enable to the controller
mem_addr  out  ADDR_W  address to the controller
mem_wdata  out  DATA_W  write data to the controller
mem_busy  in  1  controller busy; mem_stb is never issued while high
mem_done  in  1  controller completion pulse
mem_rdata  in  DATA_W  controller read data, valid with mem_done
o_owner  out  1  0 = video, 1 = CPU; owner of the current or last transaction
o_timeout_err  out  1  sticky flag, set on a watchdog timeout

Behaviour:
- Reset (async, rstn_i low): state IDLE. All outputs 0, including acks, mem_* and rdata. Streak counter 0. Watchdog counter 0. o_timeout_err 0. Reset mid-transaction abandons the transaction; no ack is issued.
- States:
  - IDLE -> ISSUE on any request.
  - ISSUE -> WAIT once mem_stb has been driven.
  - WAIT -> RESP on mem_done or on timeout.
  - RESP -> IDLE, always, after exactly one cycle.
- IDLE arbitration:
  - Only vid_req: grant video.
  - Only cpu_req: grant CPU.
  - Both high: grant CPU if streak == MAX_VID_STREAK, otherwise grant video.
  - On grant, register we/addr/wdata from the winner (video we = 0) and set o_owner.
- Streak counter:
  - Increments on each video grant made while cpu_req is high; saturates at MAX_VID_STREAK.
  - Clears to 0 on a CPU grant, or in any IDLE cycle with cpu_req low.
- ISSUE: while mem_busy is high, hold in ISSUE with mem_stb low. In the first cycle mem_busy is low, drive mem_stb=1 for exactly one cycle and go to WAIT. mem_we/addr/wdata are stable from ISSUE through WAIT.
- WAIT:
  - The watchdog counts cycles in WAIT.
  - mem_done: capture mem_rdata into the owner's rdata register, then go to RESP.
  - Watchdog reaches TIMEOUT with no mem_done: rdata = 16'hDEAD, o_timeout_err is set, then go to RESP.
  - mem_done outside WAIT is ignored.
- RESP: pulse the owner's ack for one cycle; the other ack stays 0. rdata holds until that owner's next ack.
- Handshake: the requester lowers req in the cycle after it sees ack. A req still high during the following IDLE cycle is treated as a new request.
- Latency, no contention, mem_busy low:
  - req high in IDLE at cycle N.
  - mem_stb at N+1.
  - mem_done at D.
  - ack at D+1.
  - Next grant is possible at D+2.
- cpu_we is honoured for both reads and writes. Writes still wait for mem_done and return ack; cpu_rdata is undefined on a write ack.
- Requests arriving outside IDLE wait; no queuing beyond the held req.

Decomposition:
- Package ogege_bus_pkg holds:
  - the state enum arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - constants PSRAM_ADDR_W=24, PSRAM_DATA_W=16, TIMEOUT_DATA=16'hDEAD;
  - the owner encoding OWNER_VID=0, OWNER_CPU=1.
- Single module; no sub-module is natural. The watchdog and streak counters are inline.

Test Plan:
- CPU read alone: addr 0x000123, controller returns 0xBEEF 5 cycles after mem_stb -> mem_stb at N+1 with mem_addr=0x000123 and mem_we=0; cpu_ack one cycle after mem_done; cpu_rdata=0xBEEF; vid_ack never asserts.
- CPU write: addr 0x7FFFFF, data 0x1234 -> mem_we=1, mem_wdata=0x1234, a single mem_stb pulse, cpu_ack after done.
- Contention with MAX_VID_STREAK=4: vid_req and cpu_req held continuously, video re-requesting after each ack -> grant order V,V,V,V,C,V,V,V,V,C; o_owner matches each grant.
- mem_busy held high 10 cycles after a grant -> mem_stb stays low, then pulses exactly once in the first cycle busy is low.
- No mem_done, TIMEOUT=255 -> ack exactly 256 cycles after entering WAIT; rdata=0xDEAD; o_timeout_err=1 and still 1 after later successful transactions.
- rstn_i pulsed low during WAIT -> all outputs 0 immediately; no ack; after release a new cpu_req completes normally.

Source files
------------

// File: rtl/ogege_bus_pkg.sv
// ---------------------------------------------------------------------------
// ogege_bus_pkg
// Shared types and constants for the PSRAM bus blocks.
//   arb_state_t   : arbiter FSM states
//   PSRAM_ADDR_W  : PSRAM word address width
//   PSRAM_DATA_W  : PSRAM data width
//   TIMEOUT_DATA  : read data returned when the controller never completes
//   OWNER_VID/CPU : encoding of the transaction owner flag
// ---------------------------------------------------------------------------
package ogege_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int PSRAM_ADDR_W = 24;
  localparam int PSRAM_DATA_W = 16;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

  localparam logic OWNER_VID = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

endpackage

// File: rtl/psram_arbiter.sv
// ---------------------------------------------------------------------------
// psram_arbiter
// Shares the single PSRAM controller port between the CPU bus and the video
// line-fetch engine, one word transaction at a time. Video wins ties unless
// it has already taken MAX_VID_STREAK grants in a row while the CPU waited.
// A watchdog forces completion if the controller never answers.
//
// Ports
//   clk_100mhz, rstn_i          : clock, async active-low reset
//   cpu_req/we/addr/wdata       : CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata          : CPU completion pulse and read data
//   vid_req/addr                : video read request (held until vid_ack)
//   vid_ack, vid_rdata          : video completion pulse and read data
//   mem_stb/we/addr/wdata       : transaction towards the PSRAM controller
//   mem_busy, mem_done, mem_rdata : controller status and read data
//   o_owner                     : owner of current/last transaction (1 = CPU)
//   o_timeout_err               : sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module psram_arbiter
  import ogege_bus_pkg::*;
#(
  parameter int ADDR_W         = PSRAM_ADDR_W,
  parameter int DATA_W         = PSRAM_DATA_W,
  parameter int MAX_VID_STREAK = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic              clk_100mhz,
  input  logic              rstn_i,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_stb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              o_owner,
  output logic              o_timeout_err
);

  localparam int STREAK_W = $clog2(MAX_VID_STREAK + 1);
  localparam int WDOG_W   = $clog2(TIMEOUT + 1);

  arb_state_t          state_q;
  logic [STREAK_W-1:0] streak_q;
  logic [WDOG_W-1:0]   wdogCnt_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cpuAck_q;
  logic                vidAck_q;
  logic [DATA_W-1:0]   cpuRdata_q;
  logic [DATA_W-1:0]   vidRdata_q;
  logic                timeoutErr_q;
  logic                streakFull;
  logic                grantCpu;

  // The CPU only beats a pending video request once video has used up its
  // streak allowance; otherwise video keeps priority.
  assign streakFull = (streak_q == STREAK_W'(MAX_VID_STREAK));
  assign grantCpu   = cpu_req && (!vid_req || streakFull);

  // The strobe must react to mem_busy in the same cycle so that it lands in
  // the first non-busy ISSUE cycle; it is the only combinational output.
  assign mem_stb = (state_q == ISSUE) && !mem_busy;

  // Arbiter FSM with the streak counter, watchdog and all registered outputs.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      wdogCnt_q    <= '0;
      owner_q      <= OWNER_VID;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpuAck_q     <= 1'b0;
      vidAck_q     <= 1'b0;
      cpuRdata_q   <= '0;
      vidRdata_q   <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      cpuAck_q <= 1'b0;
      vidAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!cpu_req) begin
            streak_q <= '0;
          end
          if (vid_req || cpu_req) begin
            state_q <= ISSUE;
            if (grantCpu) begin
              owner_q  <= OWNER_CPU;
              we_q     <= cpu_we;
              addr_q   <= cpu_addr;
              wdata_q  <= cpu_wdata;
              streak_q <= '0;
            end else begin
              owner_q <= OWNER_VID;
              we_q    <= 1'b0;
              addr_q  <= vid_addr;
              wdata_q <= '0;
              // Only grants that actually made the CPU wait count against it.
              if (cpu_req && !streakFull) begin
                streak_q <= streak_q + STREAK_W'(1);
              end
            end
          end
        end
        ISSUE: begin
          if (!mem_busy) begin
            state_q   <= WAIT;
            wdogCnt_q <= '0;
          end
        end
        WAIT: begin
          if (mem_done) begin
            if (owner_q == OWNER_CPU) begin
              cpuRdata_q <= mem_rdata;
            end else begin
              vidRdata_q <= mem_rdata;
            end
            cpuAck_q <= (owner_q == OWNER_CPU);
            vidAck_q <= (owner_q == OWNER_VID);
            state_q  <= RESP;
          end else if (wdogCnt_q == WDOG_W'(TIMEOUT)) begin
            if (owner_q == OWNER_CPU) begin
              cpuRdata_q <= DATA_W'(TIMEOUT_DATA);
            end else begin
              vidRdata_q <= DATA_W'(TIMEOUT_DATA);
            end
            cpuAck_q     <= (owner_q == OWNER_CPU);
            vidAck_q     <= (owner_q == OWNER_VID);
            timeoutErr_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            wdogCnt_q <= wdogCnt_q + WDOG_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ack       = cpuAck_q;
  assign vid_ack       = vidAck_q;
  assign cpu_rdata     = cpuRdata_q;
  assign vid_rdata     = vidRdata_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign o_owner       = owner_q;
  assign o_timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_psram_arbiter
// Directed bench for psram_arbiter. A transaction-level reference model
// tracks what the arbiter must be doing (free, issuing, waiting, responding)
// and checks every output on every falling edge; directed tests add
// hand-computed literal expectations for latency, data and grant order.
// ---------------------------------------------------------------------------
module tb_psram_arbiter;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int MAXV    = 4;
  localparam int TIMEOUT = 255;

  logic              clk_100mhz = 1'b0;
  logic              rstn_i;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;
  logic              mem_stb;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              o_owner;
  logic              o_timeout_err;

  logic ctrlDone;
  logic strayDone;
  int   ctrlLatency;
  bit   ctrlNoDone;
  bit   ctrlFromAddr;
  logic [DATA_W-1:0] ctrlData;

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  assign mem_done = ctrlDone | strayDone;

  psram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_VID_STREAK(MAXV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_100mhz(clk_100mhz), .rstn_i(rstn_i),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .mem_stb(mem_stb), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .o_owner(o_owner), .o_timeout_err(o_timeout_err)
  );

  // 100 MHz clock and a free-running cycle counter for latency measurements.
  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Simple controller stand-in: answers each strobe after ctrlLatency cycles
  // unless told to stay silent.
  always begin
    @(negedge clk_100mhz);
    if (rstn_i && mem_stb && !ctrlNoDone) begin
      logic [DATA_W-1:0] answer;
      answer = ctrlFromAddr ? (mem_addr[DATA_W-1:0] ^ 16'h5A5A) : ctrlData;
      repeat (ctrlLatency) @(posedge clk_100mhz);
      #1;
      ctrlDone  = 1'b1;
      mem_rdata = answer;
      @(posedge clk_100mhz);
      #1;
      ctrlDone  = 1'b0;
      mem_rdata = '0;
    end
  end

  // Reference model state: where the shared port is in its transaction life.
  typedef enum {P_FREE, P_ISSUE, P_WAIT, P_RESP} phase_t;
  phase_t            mPhase = P_FREE;
  int                mStreak = 0;
  int                mWaitCnt = 0;
  logic              mOwner = 1'b0;
  logic              mWe = 1'b0;
  logic [ADDR_W-1:0] mAddr = '0;
  logic [DATA_W-1:0] mWdata = '0;
  logic              mErr = 1'b0;
  logic [DATA_W-1:0] mCpuRd = '0;
  logic [DATA_W-1:0] mVidRd = '0;
  bit                mCpuRdKnown = 1'b1;

  // Observations recorded for the directed literal checks.
  bit                stbLog[$];
  int                stbCycle = 0;
  int                ackCycle = 0;
  int                stbCount = 0;
  int                ackCount = 0;
  int                vidAckCount = 0;
  logic [ADDR_W-1:0] stbAddr = '0;
  logic              stbWe = 1'b0;
  logic [DATA_W-1:0] stbWdata = '0;

  // Compare process: every falling edge, check the DUT against the model,
  // then advance the model by what the arbiter must do at the next edge.
  always @(negedge clk_100mhz) begin
    if (!rstn_i) begin
      mPhase = P_FREE; mStreak = 0; mOwner = 1'b0; mErr = 1'b0;
      mCpuRd = '0; mVidRd = '0; mCpuRdKnown = 1'b1;
      checkOutput("rst_cpu_ack", cpu_ack, 0);
      checkOutput("rst_vid_ack", vid_ack, 0);
      checkOutput("rst_mem_stb", mem_stb, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_owner", o_owner, 0);
      checkOutput("rst_err", o_timeout_err, 0);
      checkOutput("rst_cpu_rdata", cpu_rdata, 0);
      checkOutput("rst_vid_rdata", vid_rdata, 0);
    end else begin
      checkOutput("timeout_err", o_timeout_err, mErr);
      checkOutput("owner", o_owner, mOwner);
      checkOutput("vid_rdata", vid_rdata, mVidRd);
      if (mCpuRdKnown) checkOutput("cpu_rdata", cpu_rdata, mCpuRd);
      if (mem_stb) stbCount++;
      if (vid_ack) vidAckCount++;
      case (mPhase)
        P_FREE: begin
          checkOutput("idle_stb", mem_stb, 0);
          checkOutput("idle_cpu_ack", cpu_ack, 0);
          checkOutput("idle_vid_ack", vid_ack, 0);
          if (vid_req || cpu_req) begin
            if (cpu_req && (!vid_req || mStreak == MAXV)) begin
              mOwner = 1'b1; mWe = cpu_we; mAddr = cpu_addr; mWdata = cpu_wdata;
              mStreak = 0;
            end else begin
              mOwner = 1'b0; mWe = 1'b0; mAddr = vid_addr;
              mStreak = cpu_req ? ((mStreak < MAXV) ? mStreak + 1 : MAXV) : 0;
            end
            mPhase = P_ISSUE;
          end else begin
            mStreak = 0;
          end
        end
        P_ISSUE, P_WAIT: begin
          checkOutput("cpu_ack_busy", cpu_ack, 0);
          checkOutput("vid_ack_busy", vid_ack, 0);
          checkOutput("mem_we", mem_we, mWe);
          checkOutput("mem_addr", mem_addr, mAddr);
          if (mOwner) checkOutput("mem_wdata", mem_wdata, mWdata);
          if (mPhase == P_ISSUE) begin
            checkOutput("mem_stb_issue", mem_stb, !mem_busy);
            if (!mem_busy) begin
              stbLog.push_back(mOwner);
              stbCycle = cycle; stbAddr = mem_addr; stbWe = mem_we; stbWdata = mem_wdata;
              mPhase = P_WAIT; mWaitCnt = 0;
            end
          end else begin
            logic [DATA_W-1:0] rd;
            bit finished;
            checkOutput("mem_stb_wait", mem_stb, 0);
            mWaitCnt++;
            finished = 1'b0;
            rd = '0;
            if (mem_done) begin
              rd = mem_rdata; finished = 1'b1;
            end else if (mWaitCnt == TIMEOUT + 1) begin
              rd = 16'hDEAD; finished = 1'b1; mErr = 1'b1;
            end
            if (finished) begin
              if (mOwner) begin
                mCpuRd = rd; mCpuRdKnown = !mWe;
              end else begin
                mVidRd = rd;
              end
              mPhase = P_RESP;
            end
          end
        end
        P_RESP: begin
          checkOutput("resp_cpu_ack", cpu_ack, mOwner);
          checkOutput("resp_vid_ack", vid_ack, !mOwner);
          checkOutput("resp_stb", mem_stb, 0);
          ackCycle = cycle;
          ackCount++;
          mPhase = P_FREE;
        end
        default: mPhase = P_FREE;
      endcase
    end
  end

  task automatic applyStimulus(input bit cReq, input bit cWe, input logic [ADDR_W-1:0] cAddr,
                               input logic [DATA_W-1:0] cData, input bit vReq,
                               input logic [ADDR_W-1:0] vAddr);
    @(posedge clk_100mhz);
    #1;
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cData;
    vid_req = vReq; vid_addr = vAddr;
  endtask

  task automatic waitForAck(input bit wantCpu, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_100mhz);
      if (wantCpu ? cpu_ack : vid_ack) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL ack_wait: got no ack within %0d cycles, want ack", budget);
    end
  endtask

  // One complete requester handshake; the request drops in the IDLE cycle
  // right after the ack.
  task automatic runTransaction(input bit isCpu, input bit we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, output int reqCycle);
    applyStimulus(isCpu, we, addr, wdata, !isCpu, addr);
    reqCycle = cycle;
    waitForAck(isCpu, 600);
    @(posedge clk_100mhz);
    #1;
    cpu_req = 1'b0; vid_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got simulation still running, want finished");
    $fatal(1, "[TB] bench hung");
  end

  initial begin
    int reqCycle;
    int base;
    int vBase;
    bit expOrder[10];
    bit seen;

    expOrder = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rstn_i = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0; mem_busy = 0; ctrlDone = 0; strayDone = 0;
    mem_rdata = '0; ctrlLatency = 2; ctrlNoDone = 0; ctrlFromAddr = 0; ctrlData = '0;

    repeat (3) @(negedge clk_100mhz);
    #2 rstn_i = 1'b1;
    repeat (2) @(posedge clk_100mhz);

    $display("[TB] CPU read alone");
    ctrlLatency = 5; ctrlData = 16'hBEEF;
    vBase = vidAckCount;
    runTransaction(1, 0, 24'h000123, 16'h0, reqCycle);
    checkOutput("rd_stb_latency", stbCycle - reqCycle, 1);
    checkOutput("rd_ack_latency", ackCycle - stbCycle, 6);
    checkOutput("rd_addr", stbAddr, 24'h000123);
    checkOutput("rd_we", stbWe, 0);
    checkOutput("rd_data", cpu_rdata, 16'hBEEF);
    checkOutput("rd_no_vid_ack", vidAckCount - vBase, 0);

    $display("[TB] CPU write");
    ctrlLatency = 3; ctrlData = 16'h0F0F;
    base = stbCount;
    runTransaction(1, 1, 24'h7FFFFF, 16'h1234, reqCycle);
    checkOutput("wr_we", stbWe, 1);
    checkOutput("wr_wdata", stbWdata, 16'h1234);
    checkOutput("wr_addr", stbAddr, 24'h7FFFFF);
    checkOutput("wr_single_stb", stbCount - base, 1);
    checkOutput("wr_ack_latency", ackCycle - stbCycle, 4);

    $display("[TB] stray done while idle");
    @(posedge clk_100mhz); #1 strayDone = 1'b1;
    @(posedge clk_100mhz); #1 strayDone = 1'b0;
    repeat (4) @(posedge clk_100mhz);

    $display("[TB] contention");
    ctrlLatency = 2; ctrlFromAddr = 1;
    stbLog.delete();
    base = ackCount;
    applyStimulus(1, 0, 24'h000200, 16'h0, 1, 24'h100040);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk_100mhz);
      if (ackCount - base >= 10) seen = 1'b1;
    end
    @(posedge clk_100mhz); #1 cpu_req = 1'b0; vid_req = 1'b0;
    checkOutput("cont_done", seen, 1);
    checkOutput("cont_grants", stbLog.size(), 10);
    for (int i = 0; i < 10 && i < stbLog.size(); i++) begin
      checkOutput($sformatf("cont_order%0d", i), stbLog[i], expOrder[i]);
    end
    ctrlFromAddr = 0;
    repeat (2) @(posedge clk_100mhz);

    $display("[TB] busy controller");
    ctrlLatency = 2; ctrlData = 16'h5555;
    base = stbCount;
    applyStimulus(1, 0, 24'h000ABC, 16'h0, 0, 24'h0);
    reqCycle = cycle;
    @(posedge clk_100mhz); #1 mem_busy = 1'b1;
    repeat (10) @(posedge clk_100mhz);
    #1 mem_busy = 1'b0;
    waitForAck(1, 50);
    @(posedge clk_100mhz); #1 cpu_req = 1'b0;
    checkOutput("busy_stb_cycle", stbCycle - reqCycle, 11);
    checkOutput("busy_single_stb", stbCount - base, 1);
    checkOutput("busy_data", cpu_rdata, 16'h5555);

    $display("[TB] watchdog timeout");
    ctrlNoDone = 1;
    runTransaction(1, 0, 24'h000777, 16'h0, reqCycle);
    checkOutput("to_ack_latency", ackCycle - stbCycle, 257);
    checkOutput("to_data", cpu_rdata, 16'hDEAD);
    checkOutput("to_err", o_timeout_err, 1);
    ctrlNoDone = 0; ctrlData = 16'h7E57;
    runTransaction(0, 0, 24'h012345, 16'h0, reqCycle);
    checkOutput("to_vid_data", vid_rdata, 16'h7E57);
    checkOutput("to_err_sticky", o_timeout_err, 1);

    $display("[TB] reset during wait");
    ctrlNoDone = 1;
    base = ackCount;
    applyStimulus(1, 0, 24'h000456, 16'h0, 0, 24'h0);
    repeat (5) @(posedge clk_100mhz);
    #3 rstn_i = 1'b0;
    #1;
    checkOutput("rstw_cpu_ack", cpu_ack, 0);
    checkOutput("rstw_vid_ack", vid_ack, 0);
    checkOutput("rstw_stb", mem_stb, 0);
    checkOutput("rstw_we", mem_we, 0);
    checkOutput("rstw_addr", mem_addr, 0);
    checkOutput("rstw_wdata", mem_wdata, 0);
    checkOutput("rstw_cpu_rdata", cpu_rdata, 0);
    checkOutput("rstw_vid_rdata", vid_rdata, 0);
    checkOutput("rstw_owner", o_owner, 0);
    checkOutput("rstw_err", o_timeout_err, 0);
    @(posedge clk_100mhz); #1 cpu_req = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    @(negedge clk_100mhz); #2 rstn_i = 1'b1;
    ctrlNoDone = 0; ctrlLatency = 1; ctrlData = 16'hCAFE;
    repeat (3) @(posedge clk_100mhz);
    checkOutput("rstw_no_ack", ackCount - base, 0);
    runTransaction(1, 0, 24'h000456, 16'h0, reqCycle);
    checkOutput("rstw_after_data", cpu_rdata, 16'hCAFE);
    checkOutput("rstw_after_latency", ackCycle - stbCycle, 2);

    repeat (3) @(posedge clk_100mhz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
